serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the single-bit combinational full adder.
- Processes DIGIT bits per clock, LSB first, over a WIDTH-bit operand pair.
- Uses valid/ready handshakes on input and output so it plugs into the tile's streaming datapath.
- Supports add and subtract modes with carry-in, carry-out and signed-overflow reporting; one operation in flight at a time.

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB first, with
// valid/ready handshakes on both sides and one operation in flight at a time.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
            $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             carry_d;
    logic             msb_cin;

    always_comb begin
        a_dig = a_q[cnt_q*DIGIT +: DIGIT];
        b_dig = b_q[cnt_q*DIGIT +: DIGIT];
        {carry_d, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the digit's top bit, recovered from its sum bit.
        msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt_q*DIGIT +: DIGIT] <= s_dig;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        cout_q      <= carry_d;
                        ovf_q       <= msb_cin ^ carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: four WIDTH=8 instances (DIGIT 1,2,4,8) checked against a
// plain-arithmetic reference, with directed vectors, backpressure and async reset.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_valid  = '0;
    logic [3:0] in_ready;
    logic [3:0] cin       = '0;
    logic [3:0] sub       = '0;
    logic [3:0] out_valid;
    logic [3:0] out_ready = '0;
    logic [3:0] cout;
    logic [3:0] ovf;
    logic [3:0] busy;
    logic [7:0] a_v   [4];
    logic [7:0] b_v   [4];
    logic [7:0] sum_w [4];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .cin       (cin[g]),
            .sub       (sub[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum       (sum_w[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: two's-complement add of a and the effective B; overflow when
    // both addends share a sign that the result does not.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
        logic [7:0] be;
        logic [8:0] full;
        logic       ov;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {8'd0, ci};
        ov   = (a[7] == be[7]) && (full[7] != a[7]);
        return {ov, full[8], full[7:0]};
    endfunction

    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input int hold);
        logic [9:0] exp;
        int         n;
        exp = model(a, b, ci, sb);
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready[k]) check("ready_timeout", 32'(in_ready[k]), 32'd1);
        a_v[k] = a; b_v[k] = b; cin[k] = ci; sub[k] = sb;
        in_valid[k]  = 1'b1;
        out_ready[k] = (hold == 0);
        @(posedge clk); #1;
        // Operands may change and in_valid is ignored once accepted.
        in_valid[k] = (hold > 0);
        a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
        cin[k] = 1'($urandom); sub[k] = 1'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!out_valid[k] && n < 40);
        check("latency", 32'(n), 32'(8 >> k));
        check("sum",  32'(sum_w[k]), 32'(exp[7:0]));
        check("cout", 32'(cout[k]),  32'(exp[8]));
        check("ovf",  32'(ovf[k]),   32'(exp[9]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid[k]), 32'd1);
            check("bp_ready", 32'(in_ready[k]),  32'd0);
            check("bp_sum",   32'(sum_w[k]),     32'(exp[7:0]));
            check("bp_cout",  32'(cout[k]),      32'(exp[8]));
            check("bp_ovf",   32'(ovf[k]),       32'(exp[9]));
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(out_valid[k]), 32'd0);
        check("post_busy",  32'(busy[k]),      32'd0);
        check("post_ready", 32'(in_ready[k]),  32'd1);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        #12 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", 32'(in_ready[i]),  32'd1);
            check("rst_valid", 32'(out_valid[i]), 32'd0);
            check("rst_sum",   32'(sum_w[i]),     32'd0);
            check("rst_busy",  32'(busy[i]),      32'd0);
        end

        run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, 0);
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b1, 0);
        run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0);
        run_op(0, 8'hC3, 8'h5A, 1'b0, 1'b0, 5);
        run_op(2, 8'hF0, 8'h10, 1'b0, 1'b0, 0);

        // Abort mid-operation with reset asserted between clock edges.
        a_v[0] = 8'h33; b_v[0] = 8'h44; cin[0] = 1'b0; sub[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sum",   32'(sum_w[0]),     32'd0);
        check("arst_cout",  32'(cout[0]),      32'd0);
        check("arst_ovf",   32'(ovf[0]),       32'd0);
        check("arst_valid", 32'(out_valid[0]), 32'd0);
        check("arst_busy",  32'(busy[0]),      32'd0);
        check("arst_ready", 32'(in_ready[0]),  32'd1);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 0);
        check("arst_next", 32'(sum_w[0]), 32'h02);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 250; i++) begin
                run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
